// File: rtl/instr_mem_loader.sv
// instr_mem_loader: streams 32-bit words into byte-wide instr memory, MSB first.
// Ports: start/abort/base_addr/length ctrl, in_* stream, mem_* write, busy/done/err/words_loaded.
module instr_mem_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [5:0]        length,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [5:0]        words_loaded
);

  localparam int SUM_W = ADDR_W + 2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCEPT,
    S_WRITE,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [5:0]        len_q, len_d;
  logic [31:0]       word_q, word_d;
  logic [5:0]        words_q, words_d;
  logic              err_q, err_d;
  logic              in_ready_q, in_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [SUM_W-1:0]  end_addr;
  logic              range_bad;
  logic [5:0]        words_inc;

  // One past the last byte the load would touch; equal to DEPTH is legal.
  assign end_addr  = SUM_W'(base_addr)
                   + SUM_W'({length, 2'b00});
  assign range_bad = end_addr > SUM_W'(DEPTH);
  assign words_inc = words_q + 6'd1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    len_d      = len_q;
    word_d     = word_q;
    words_d    = words_q;
    err_d      = err_q;
    in_ready_d = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;

    if (abort) begin
      state_d = S_IDLE;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          busy_d = 1'b0;
          if (start) begin
            addr_d  = base_addr;
            len_d   = length;
            words_d = 6'd0;
            err_d   = 1'b0;
            if (length == 6'd0) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (range_bad) begin
              err_d   = 1'b1;
              state_d = S_DONE;
              done_d  = 1'b1;
            end else begin
              state_d    = S_ACCEPT;
              busy_d     = 1'b1;
              in_ready_d = 1'b1;
            end
          end
        end

        S_ACCEPT: begin
          busy_d = 1'b1;
          if (in_valid && in_ready_q) begin
            // Byte 0 goes out straight from the bus.
            word_d     = in_data;
            state_d    = S_WRITE;
            idx_d      = 2'd0;
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            mem_data_d = in_data[31:24];
            addr_d     = addr_q + ADDR_W'(1);
          end else begin
            in_ready_d = 1'b1;
          end
        end

        S_WRITE: begin
          busy_d = 1'b1;
          // idx_q is the byte on the bus this cycle.
          if (idx_q != 2'd3) begin
            idx_d      = idx_q + 2'd1;
            mem_we_d   = 1'b1;
            mem_addr_d = addr_q;
            addr_d     = addr_q + ADDR_W'(1);
            case (idx_q)
              2'd0:    mem_data_d = word_q[23:16];
              2'd1:    mem_data_d = word_q[15:8];
              default: mem_data_d = word_q[7:0];
            endcase
          end else begin
            words_d = words_inc;
            if (words_inc == len_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end else begin
              state_d    = S_ACCEPT;
              in_ready_d = 1'b1;
            end
          end
        end

        S_DONE: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= 2'd0;
      addr_q     <= '0;
      len_q      <= 6'd0;
      word_q     <= 32'd0;
      words_q    <= 6'd0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      word_q     <= word_d;
      words_q    <= words_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed bench for instr_mem_loader.
// Writes are mirrored into a shadow memory and counted on the falling edge.
module tb_instr_mem_loader;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [6:0] base_addr;
  logic [5:0] length;
  logic       in_valid;
  logic [31:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [6:0] mem_addr;
  logic [7:0] mem_data;
  logic       busy;
  logic       done;
  logic       err;
  logic [5:0] words_loaded;

  int checks;
  int errors;
  int wr_cnt;
  int done_cnt;
  int busy_cnt;
  int w0;
  int d0;
  int b0;
  logic [7:0] tmem [128];

  instr_mem_loader #(.ADDR_W(7), .DEPTH(128)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .base_addr    (base_addr),
    .length       (length),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    wr_cnt   = 0;
    done_cnt = 0;
    busy_cnt = 0;
    for (int i = 0; i < 128; i++) tmem[i] = 8'h00;
  end

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      tmem[mem_addr] = mem_data;
      wr_cnt++;
    end
    if (done === 1'b1) done_cnt++;
    if (busy === 1'b1) busy_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    w0 = wr_cnt;
    d0 = done_cnt;
    b0 = busy_cnt;
  endtask

  function automatic logic [31:0] outs();
    return {6'd0, in_ready, mem_we, mem_addr, mem_data,
            busy, done, err, words_loaded};
  endfunction

  function automatic logic [31:0] wd(input int a);
    return {tmem[a], tmem[a+1], tmem[a+2], tmem[a+3]};
  endfunction

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    base_addr = 7'd0;
    length    = 6'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    repeat (2) step();
    chk("reset_outs", outs(), 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_outs", outs(), 32'd0);

    // Two-word load from address 0, stream always valid.
    snap();
    base_addr = 7'd0;
    length    = 6'd2;
    in_data   = 32'h12345678;
    in_valid  = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy", busy, 1);
    chk("t1_rdy", in_ready, 1);
    chk("t1_we_pre", mem_we, 0);
    step();
    chk("t1_we0", mem_we, 1);
    chk("t1_rdy_lo", in_ready, 0);
    chk("t1_b0", {mem_addr, mem_data}, {7'd0, 8'h12});
    in_data = 32'h9ABCDEF0;
    repeat (3) step();
    chk("t1_b3", {mem_addr, mem_data}, {7'd3, 8'h78});
    step();
    chk("t1_acc2_rdy", in_ready, 1);
    chk("t1_acc2_we", mem_we, 0);
    chk("t1_wl1", words_loaded, 1);
    step();
    chk("t1_b4", {mem_addr, mem_data}, {7'd4, 8'h9A});
    repeat (3) step();
    chk("t1_b7", {mem_addr, mem_data}, {7'd7, 8'hF0});
    step();
    chk("t1_done", done, 1);
    chk("t1_busy_lo", busy, 0);
    chk("t1_wl2", words_loaded, 2);
    chk("t1_err", err, 0);
    step();
    chk("t1_done_lo", done, 0);
    in_valid = 1'b0;
    chk("t1_wrcnt", wr_cnt - w0, 8);
    chk("t1_donecnt", done_cnt - d0, 1);
    chk("t1_w0", wd(0), 32'h12345678);
    chk("t1_w1", wd(4), 32'h9ABCDEF0);

    // Last legal word ends at byte 127.
    snap();
    base_addr = 7'd124;
    length    = 6'd1;
    in_data   = 32'hCAFEBABE;
    in_valid  = 1'b1;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    chk("t2_b0", {mem_addr, mem_data}, {7'd124, 8'hCA});
    in_valid = 1'b0;
    repeat (3) step();
    chk("t2_b3", {mem_we, mem_addr, mem_data}, {1'b1, 7'd127, 8'hBE});
    step();
    chk("t2_done", {done, err, busy}, 3'b100);
    step();
    chk("t2_wrcnt", wr_cnt - w0, 4);
    chk("t2_word", wd(124), 32'hCAFEBABE);

    // One byte past the end: range error, no writes.
    snap();
    base_addr = 7'd125;
    length    = 6'd1;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("t2b_done_err", {done, err, busy, mem_we}, 4'b1100);
    step();
    chk("t2b_err_hold", {done, err}, 2'b01);
    chk("t2b_wrcnt", wr_cnt - w0, 0);

    // Zero-length load: immediate done, err cleared, never busy.
    snap();
    base_addr = 7'd10;
    length    = 6'd0;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("t3_done_err", {done, err}, 2'b10);
    step();
    chk("t3_done_lo", done, 0);
    chk("t3_busycnt", busy_cnt - b0, 0);
    chk("t3_wrcnt", wr_cnt - w0, 0);

    // Source stalls 3 cycles; start during WRITE is ignored.
    snap();
    base_addr = 7'd16;
    length    = 6'd1;
    in_valid  = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall", {in_ready, mem_we}, 2'b10);
      step();
    end
    chk("t4_stall_end", {in_ready, mem_we}, 2'b10);
    in_valid = 1'b1;
    in_data  = 32'h01020304;
    step();
    in_valid = 1'b0;
    chk("t4_b0", {mem_we, mem_addr, mem_data}, {1'b1, 7'd16, 8'h01});
    start     = 1'b1;
    base_addr = 7'd50;
    step();
    start = 1'b0;
    chk("t4_b1", {mem_addr, mem_data}, {7'd17, 8'h02});
    repeat (2) step();
    chk("t4_b3", {mem_addr, mem_data}, {7'd19, 8'h04});
    step();
    chk("t4_done", {done, words_loaded}, {1'b1, 6'd1});
    step();
    chk("t4_idle", {busy, in_ready, done}, 3'b000);
    chk("t4_word", wd(16), 32'h01020304);
    chk("t4_wrcnt", wr_cnt - w0, 4);

    // Abort during byte 2 of word 2 of a 3-word load.
    snap();
    base_addr = 7'd32;
    length    = 6'd3;
    in_valid  = 1'b1;
    in_data   = 32'h11223344;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    in_data = 32'h55667788;
    repeat (4) step();
    chk("t5_acc2", {in_ready, words_loaded}, {1'b1, 6'd1});
    step();
    chk("t5_w2b0", {mem_addr, mem_data}, {7'd36, 8'h55});
    repeat (2) step();
    chk("t5_w2b2", {mem_we, mem_addr, mem_data}, {1'b1, 7'd38, 8'h77});
    abort = 1'b1;
    step();
    abort    = 1'b0;
    in_valid = 1'b0;
    chk("t5_abort", {mem_we, in_ready, busy, done}, 4'b0000);
    chk("t5_wl", words_loaded, 1);
    chk("t5_err", err, 0);
    repeat (2) step();
    chk("t5_nodone", done_cnt - d0, 0);
    chk("t5_wrcnt", wr_cnt - w0, 7);
    chk("t5_w1", wd(32), 32'h11223344);
    chk("t5_partial", wd(36), 32'h55667700);

    // Set err, then a fresh valid load clears it.
    base_addr = 7'd100;
    length    = 6'd8;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("t5_err_set", err, 1);
    step();
    snap();
    base_addr = 7'd40;
    length    = 6'd1;
    in_valid  = 1'b1;
    in_data   = 32'hA5C3E1F0;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("t5_restart", {err, busy}, 2'b01);
    step();
    in_valid = 1'b0;
    repeat (3) step();
    step();
    chk("t5_re_done", {done, err, words_loaded}, {2'b10, 6'd1});
    step();
    chk("t5_re_word", wd(40), 32'hA5C3E1F0);

    // Asynchronous reset in the middle of a write.
    base_addr = 7'd64;
    length    = 6'd2;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    chk("t6_mid", mem_we, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async", outs(), 32'd0);
    step();
    step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    step();
    chk("t6_idle", outs(), 32'd0);
    snap();
    base_addr = 7'd100;
    length    = 6'd1;
    in_valid  = 1'b1;
    in_data   = 32'h0BADF00D;
    start     = 1'b1;
    step();
    start = 1'b0;
    chk("t6_start", {busy, in_ready}, 2'b11);
    step();
    in_valid = 1'b0;
    chk("t6_b0", {mem_addr, mem_data}, {7'd100, 8'h0B});
    repeat (3) step();
    step();
    chk("t6_done", done, 1);
    step();
    chk("t6_word", wd(100), 32'h0BADF00D);
    chk("t6_wrcnt", wr_cnt - w0, 4);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
